// File: rtl/pc_sequencer.sv
// Program-counter register and run-control FSM feeding the CPU core's pc_i.
// Gates PC updates with run/pause/step/halt, latches halt cause/PC and keeps perf counters.
module pc_sequencer #(
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(64'h8000_0000),
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] new_pc_i,
  input  logic [7:0]            exceptions_i,
  input  logic                  run_i,
  input  logic                  step_req_i,
  input  logic                  clear_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  step_ack_o,
  output logic                  halted_o,
  output logic [8:0]            halt_cause_o,
  output logic [DATA_WIDTH-1:0] halt_pc_o,
  output logic [CNT_WIDTH-1:0]  retire_cnt_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  redirect_cnt_o
);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] halt_pc_q, halt_pc_d;
  logic [8:0]            cause_q, cause_d;
  logic                  step_ack_q, step_ack_d;
  logic                  halted_q, halted_d;
  logic [CNT_WIDTH-1:0]  retire_q, retire_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;
  logic [CNT_WIDTH-1:0]  redirect_q, redirect_d;

  logic                  exc_hit;
  logic                  mis_hit;
  logic                  do_update;
  logic [DATA_WIDTH-1:0] pc_plus4;

  assign exc_hit  = (exceptions_i != 8'd0);
  assign mis_hit  = (new_pc_i[1:0] != 2'b00);
  // Wraps modulo 2^DATA_WIDTH, so the top-of-space to zero step counts as sequential.
  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    halt_pc_d  = halt_pc_q;
    cause_d    = cause_q;
    retire_d   = retire_q;
    stall_d    = stall_q;
    redirect_d = redirect_q;
    do_update  = 1'b0;

    case (state_q)
      ST_PAUSE: begin
        if (run_i) begin
          state_d = ST_RUN;
        end else if (step_req_i) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN, ST_STEP: begin
        if (exc_hit) begin
          state_d   = ST_HALT;
          cause_d   = {1'b0, exceptions_i};
          halt_pc_d = pc_q;
        end else if (mis_hit) begin
          state_d   = ST_HALT;
          cause_d   = 9'h100;
          halt_pc_d = pc_q;
        end else if (state_q == ST_RUN && !run_i) begin
          state_d = ST_PAUSE;
        end else begin
          do_update = 1'b1;
          state_d   = (state_q == ST_RUN) ? ST_RUN : ST_PAUSE;
        end
      end
      ST_HALT: begin
        if (clear_i) begin
          state_d = ST_PAUSE;
          cause_d = 9'd0;
        end
      end
      default: state_d = ST_PAUSE;
    endcase

    // Stall/redirect classification is against the PC before this update.
    if (do_update) begin
      pc_d     = new_pc_i;
      retire_d = retire_q + CNT_WIDTH'(1);
      if (new_pc_i == pc_q) begin
        stall_d = stall_q + CNT_WIDTH'(1);
      end else if (new_pc_i != pc_plus4) begin
        redirect_d = redirect_q + CNT_WIDTH'(1);
      end
    end

    step_ack_d = (state_q == ST_STEP);
    halted_d   = (state_d == ST_HALT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_PAUSE;
      pc_q       <= RESET_PC;
      halt_pc_q  <= '0;
      cause_q    <= '0;
      step_ack_q <= 1'b0;
      halted_q   <= 1'b0;
      retire_q   <= '0;
      stall_q    <= '0;
      redirect_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      halt_pc_q  <= halt_pc_d;
      cause_q    <= cause_d;
      step_ack_q <= step_ack_d;
      halted_q   <= halted_d;
      retire_q   <= retire_d;
      stall_q    <= stall_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc_o           = pc_q;
  assign step_ack_o     = step_ack_q;
  assign halted_o       = halted_q;
  assign halt_cause_o   = cause_q;
  assign halt_pc_o      = halt_pc_q;
  assign retire_cnt_o   = retire_q;
  assign stall_cnt_o    = stall_q;
  assign redirect_cnt_o = redirect_q;

endmodule
